// File: rtl/s_axi_mem_resp.sv
`timescale 1ns/1ps
// AXI4 slave memory responder: INCR bursts on independent read and write channels
// served from an internal read-first block RAM, one outstanding burst per direction.
module s_axi_mem_resp #(
    parameter int C_DATA_WIDTH = 128,
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_MEM_DEPTH  = 4096
) (
    input  logic                      I_clk,
    input  logic                      I_rst,
    input  logic [C_ADDR_WIDTH-1:0]   I_awaddr,
    input  logic [7:0]                I_awlen,
    input  logic [3:0]                I_awid,
    input  logic                      I_awvalid,
    output logic                      O_awready,
    input  logic [C_DATA_WIDTH-1:0]   I_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] I_wstrb,
    input  logic                      I_wlast,
    input  logic                      I_wvalid,
    output logic                      O_wready,
    output logic [1:0]                O_bresp,
    output logic [3:0]                O_bid,
    output logic                      O_bvalid,
    input  logic                      I_bready,
    input  logic [C_ADDR_WIDTH-1:0]   I_araddr,
    input  logic [7:0]                I_arlen,
    input  logic [3:0]                I_arid,
    input  logic                      I_arvalid,
    output logic                      O_arready,
    output logic [C_DATA_WIDTH-1:0]   O_rdata,
    output logic [1:0]                O_rresp,
    output logic [3:0]                O_rid,
    output logic                      O_rlast,
    output logic                      O_rvalid,
    input  logic                      I_rready
);
    localparam int STRB_W = C_DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(C_MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_BURST} r_state_t;

    // Every channel transfers on a rising edge where valid and ready are both high;
    // the source holds valid and payload stable until that edge.

    logic unused_addr_bits;
    assign unused_addr_bits = ^{I_awaddr, I_araddr};

    // Low during reset and for one cycle after release, so the ready outputs stay 0.
    logic run;
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) run <= 1'b0;
        else       run <= 1'b1;
    end

    logic [C_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];
    logic [C_DATA_WIDTH-1:0] ram_rdata;
    logic                    ram_re;
    logic                    ram_we;
    logic [IDX_W-1:0]        w_idx;
    logic [IDX_W-1:0]        r_idx;

    // Non-blocking read and write of the same entry returns the old contents.
    always_ff @(posedge I_clk) begin
        if (ram_re) ram_rdata <= mem[r_idx];
        if (ram_we)
            for (int b = 0; b < STRB_W; b++)
                if (I_wstrb[b]) mem[w_idx][b*8 +: 8] <= I_wdata[b*8 +: 8];
    end

    w_state_t   w_state, w_state_nxt;
    logic [7:0] w_len, w_cnt;
    logic [3:0] w_id;
    logic       w_err;
    logic       aw_hs, w_hs;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) w_state <= W_IDLE;
        else       w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        O_awready   = 1'b0;
        O_wready    = 1'b0;
        O_bvalid    = 1'b0;
        case (w_state)
            W_IDLE: begin
                O_awready = run;
                if (I_awvalid && run) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                O_wready = 1'b1;
                if (I_wvalid && w_cnt == w_len) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                O_bvalid = 1'b1;
                if (I_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_hs   = I_awvalid & O_awready;
    assign w_hs    = I_wvalid & O_wready;
    assign ram_we  = w_hs;
    assign O_bresp = (O_bvalid && w_err) ? 2'b10 : 2'b00;
    assign O_bid   = w_id;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            w_idx <= '0;
            w_len <= '0;
            w_cnt <= '0;
            w_id  <= '0;
            w_err <= 1'b0;
        end else if (aw_hs) begin
            w_idx <= I_awaddr[OFF_W +: IDX_W];
            w_len <= I_awlen;
            w_id  <= I_awid;
            w_cnt <= '0;
            w_err <= 1'b0;
        end else if (w_hs) begin
            w_idx <= w_idx + IDX_W'(1);
            w_cnt <= w_cnt + 8'd1;
            // wlast must coincide exactly with the final counted beat
            if ((I_wlast && w_cnt < w_len) || (!I_wlast && w_cnt == w_len)) w_err <= 1'b1;
        end
    end

    r_state_t                r_state, r_state_nxt;
    logic [7:0]              r_len;
    logic [8:0]              r_issued;
    logic [3:0]              r_id;
    logic                    inflight, inflight_last;
    logic [C_DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]              buf_last;
    logic                    rptr, wptr;
    logic [1:0]              count, occ;
    logic                    ar_hs, r_pop;

    assign O_rvalid = (count != 2'd0);
    assign O_rdata  = buf_data[rptr];
    assign O_rlast  = O_rvalid & buf_last[rptr];
    assign O_rresp  = 2'b00;
    assign O_rid    = r_id;
    assign r_pop    = O_rvalid & I_rready;
    assign ar_hs    = I_arvalid & O_arready;
    // Buffer occupancy after this cycle's pop, counting the read still in the RAM.
    assign occ      = count + {1'b0, inflight} - {1'b0, r_pop};

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) r_state <= R_IDLE;
        else       r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        O_arready   = 1'b0;
        ram_re      = 1'b0;
        case (r_state)
            R_IDLE: begin
                O_arready = run;
                if (I_arvalid && run) r_state_nxt = R_BURST;
            end
            R_BURST: begin
                ram_re = (r_issued <= {1'b0, r_len}) && (occ < 2'd2);
                if (r_pop && O_rlast) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_idx         <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_id          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            buf_last      <= '0;
            rptr          <= 1'b0;
            wptr          <= 1'b0;
            count         <= '0;
        end else begin
            if (ar_hs) begin
                r_idx    <= I_araddr[OFF_W +: IDX_W];
                r_len    <= I_arlen;
                r_id     <= I_arid;
                r_issued <= '0;
            end else if (ram_re) begin
                r_idx    <= r_idx + IDX_W'(1);
                r_issued <= r_issued + 9'd1;
            end
            inflight      <= ram_re;
            inflight_last <= (r_issued == {1'b0, r_len});
            if (inflight) begin
                buf_data[wptr] <= ram_rdata;
                buf_last[wptr] <= inflight_last;
                wptr           <= ~wptr;
            end
            if (r_pop) rptr <= ~rptr;
            count <= count + {1'b0, inflight} - {1'b0, r_pop};
        end
    end
endmodule

// File: tb/tb_s_axi_mem_resp.sv
`timescale 1ns/1ps
// Bench for s_axi_mem_resp: a word-array memory model predicts every R beat through
// an expected queue; B responses are predicted from the burst length and wlast position.
module tb_s_axi_mem_resp;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam int DEPTH = 4096;
    localparam int IDX_W = 12;
    localparam int BYTES = DW / 8;

    logic I_clk, I_rst;
    logic [AW-1:0] I_awaddr, I_araddr;
    logic [7:0] I_awlen, I_arlen;
    logic [3:0] I_awid, I_arid;
    logic I_awvalid, O_awready;
    logic [DW-1:0] I_wdata;
    logic [BYTES-1:0] I_wstrb;
    logic I_wlast, I_wvalid, O_wready;
    logic [1:0] O_bresp, O_rresp;
    logic [3:0] O_bid, O_rid;
    logic O_bvalid, I_bready;
    logic I_arvalid, O_arready;
    logic [DW-1:0] O_rdata;
    logic O_rlast, O_rvalid, I_rready;

    s_axi_mem_resp #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW), .C_MEM_DEPTH(DEPTH)) dut (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_awaddr(I_awaddr), .I_awlen(I_awlen), .I_awid(I_awid), .I_awvalid(I_awvalid),
        .O_awready(O_awready),
        .I_wdata(I_wdata), .I_wstrb(I_wstrb), .I_wlast(I_wlast), .I_wvalid(I_wvalid),
        .O_wready(O_wready),
        .O_bresp(O_bresp), .O_bid(O_bid), .O_bvalid(O_bvalid), .I_bready(I_bready),
        .I_araddr(I_araddr), .I_arlen(I_arlen), .I_arid(I_arid), .I_arvalid(I_arvalid),
        .O_arready(O_arready),
        .O_rdata(O_rdata), .O_rresp(O_rresp), .O_rid(O_rid), .O_rlast(O_rlast),
        .O_rvalid(O_rvalid), .I_rready(I_rready)
    );

    // clock / reset
    initial begin
        I_clk = 1'b0;
        forever #5 I_clk = ~I_clk;
    end

    int checks = 0;
    int errors = 0;
    logic [DW-1:0]    model_mem [DEPTH];
    logic [DW-1:0]    exp_q [$];
    logic [DW-1:0]    wdata_tab [256];
    logic [BYTES-1:0] wstrb_tab [256];
    logic [DW-1:0]    last_rdata;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int beat_base(input logic [AW-1:0] addr);
        return int'(addr / 32'(BYTES)) % DEPTH;
    endfunction

    // driver: one write burst from wdata_tab/wstrb_tab, model updated per accepted beat
    task automatic write_burst(input logic [AW-1:0] addr, input int len, input logic [3:0] id,
                               input int wlast_at, input bit gaps,
                               output logic [1:0] bresp, output logic [3:0] bid);
        int base, guard;
        logic [IDX_W-1:0] mi;
        base = beat_base(addr);
        @(posedge I_clk); #1;
        I_awaddr = addr; I_awlen = len[7:0]; I_awid = id; I_awvalid = 1'b1;
        guard = 0;
        do begin @(negedge I_clk); guard++; end while (!O_awready && guard < 100);
        check_bit("aw_ready", O_awready, 1'b1);
        @(posedge I_clk); #1;
        I_awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                I_wvalid = 1'b0;
                @(posedge I_clk); #1;
            end
            I_wdata = wdata_tab[b]; I_wstrb = wstrb_tab[b]; I_wlast = (b == wlast_at); I_wvalid = 1'b1;
            guard = 0;
            do begin @(negedge I_clk); guard++; end while (!O_wready && guard < 100);
            check_bit("w_ready", O_wready, 1'b1);
            mi = IDX_W'(base + b);
            for (int k = 0; k < BYTES; k++)
                if (wstrb_tab[b][k]) model_mem[mi][k*8 +: 8] = wdata_tab[b][k*8 +: 8];
            @(posedge I_clk); #1;
        end
        I_wvalid = 1'b0; I_wlast = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) @(posedge I_clk);
        #1 I_bready = 1'b1;
        guard = 0;
        do begin @(negedge I_clk); guard++; end while (!O_bvalid && guard < 100);
        check_bit("b_valid", O_bvalid, 1'b1);
        bresp = O_bresp; bid = O_bid;
        @(posedge I_clk); #1;
        I_bready = 1'b0;
        @(negedge I_clk);
        check_bit("aw_ready_after_b", O_awready, 1'b1);
    endtask

    // driver + scoreboard: one read burst; mode 0 rready high, 1 toggling, 2 random
    task automatic read_burst(input logic [AW-1:0] addr, input int len, input logic [3:0] id,
                              input int mode, input int abort_after);
        int base, guard, cyc, got;
        bit seen, prev_stall;
        logic [DW-1:0] prev_data, exp_v;
        logic prev_last;
        base = beat_base(addr);
        exp_q.delete();
        for (int b = 0; b <= len; b++) exp_q.push_back(model_mem[IDX_W'(base + b)]);
        @(posedge I_clk); #1;
        I_araddr = addr; I_arlen = len[7:0]; I_arid = id; I_arvalid = 1'b1; I_rready = 1'b0;
        guard = 0;
        do begin @(negedge I_clk); guard++; end while (!O_arready && guard < 100);
        check_bit("ar_ready", O_arready, 1'b1);
        @(posedge I_clk); #1;
        I_arvalid = 1'b0;
        cyc = 0; got = 0; seen = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
        while (got <= len && cyc < 2000) begin
            case (mode)
                0: I_rready = 1'b1;
                1: I_rready = (cyc % 2 == 0);
                default: I_rready = 1'($urandom_range(0, 1));
            endcase
            @(negedge I_clk);
            if (!seen && O_rvalid) begin
                seen = 1;
                check_int("first_rvalid_latency", cyc, 2);
            end
            if (seen) check_bit("r_valid_continuous", O_rvalid, 1'b1);
            if (prev_stall) begin
                check_data("r_hold_data", O_rdata, prev_data);
                check_bit("r_hold_last", O_rlast, prev_last);
            end
            if (O_rvalid && I_rready) begin
                check_bit("r_beat_expected", exp_q.size() != 0, 1'b1);
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check_data("r_data", O_rdata, exp_v);
                check_bit("r_last", O_rlast, got == len);
                check_int("r_id", int'(O_rid), int'(id));
                check_int("r_resp", int'(O_rresp), 0);
                last_rdata = O_rdata;
                got++;
                if (abort_after > 0 && got == abort_after) break;
            end
            prev_stall = O_rvalid && !I_rready;
            prev_data = O_rdata;
            prev_last = O_rlast;
            @(posedge I_clk); #1;
            cyc++;
        end
        if (abort_after > 0) begin
            @(posedge I_clk); #2;
            I_rst = 1'b1; #1;
            check_bit("rst_rvalid_drop", O_rvalid, 1'b0);
            check_bit("rst_arready_low", O_arready, 1'b0);
            check_data("rst_rdata_zero", O_rdata, '0);
            repeat (2) @(negedge I_clk);
            I_rst = 1'b0; I_rready = 1'b0; #1;
            check_bit("rel_arready_wait", O_arready, 1'b0);
            @(negedge I_clk);
            check_bit("rel_arready_up", O_arready, 1'b1);
            check_bit("rel_awready_up", O_awready, 1'b1);
            exp_q.delete();
            return;
        end
        I_rready = 1'b0;
        check_int("r_beats", got, len + 1);
        check_int("r_queue_empty", exp_q.size(), 0);
        @(negedge I_clk);
        check_bit("ar_ready_after_last", O_arready, 1'b1);
        check_bit("r_valid_after_last", O_rvalid, 1'b0);
    endtask

    logic [1:0] bresp;
    logic [3:0] bid;

    initial begin
        I_rst = 1'b1;
        I_awaddr = '0; I_awlen = '0; I_awid = '0; I_awvalid = 1'b0;
        I_wdata = '0; I_wstrb = '0; I_wlast = 1'b0; I_wvalid = 1'b0; I_bready = 1'b0;
        I_araddr = '0; I_arlen = '0; I_arid = '0; I_arvalid = 1'b0; I_rready = 1'b0;
        last_rdata = '0;
        repeat (3) @(posedge I_clk);
        @(negedge I_clk);
        check_bit("rst_awready", O_awready, 1'b0);
        check_bit("rst_wready", O_wready, 1'b0);
        check_bit("rst_bvalid", O_bvalid, 1'b0);
        check_bit("rst_arready", O_arready, 1'b0);
        check_bit("rst_rvalid", O_rvalid, 1'b0);
        check_bit("rst_rlast", O_rlast, 1'b0);
        check_data("rst_rdata", O_rdata, '0);
        check_int("rst_ids", int'({O_bid, O_rid}), 0);
        check_int("rst_resps", int'({O_bresp, O_rresp}), 0);
        I_rst = 1'b0;
        @(negedge I_clk);
        check_bit("init_awready", O_awready, 1'b1);
        check_bit("init_arready", O_arready, 1'b1);

        // 16-beat write of the beat index, then read back
        for (int b = 0; b < 16; b++) begin wdata_tab[b] = DW'(b); wstrb_tab[b] = '1; end
        write_burst(32'h100, 15, 4'h5, 15, 0, bresp, bid);
        check_int("wr16_bresp", int'(bresp), 0);
        check_int("wr16_bid", int'(bid), 5);
        read_burst(32'h100, 15, 4'h9, 0, 0);
        check_data("rd16_last_value", last_rdata, DW'(15));

        // 256-beat fill of indices 1024..1279, read back with rready toggling
        for (int b = 0; b < 256; b++) begin
            wdata_tab[b] = {$urandom, $urandom, $urandom, $urandom};
            wstrb_tab[b] = '1;
        end
        write_burst(32'h4000, 255, 4'h3, 255, 1, bresp, bid);
        check_int("wr256_bresp", int'(bresp), 0);
        read_burst(32'h4000, 255, 4'hA, 1, 0);

        // wlast on the wrong beat still writes all beats but reports SLVERR
        for (int b = 0; b < 4; b++) begin wdata_tab[b] = {$urandom, $urandom, $urandom, $urandom}; wstrb_tab[b] = '1; end
        write_burst(32'h2000, 3, 4'h7, 1, 0, bresp, bid);
        check_int("early_wlast_bresp", int'(bresp), 2);
        check_int("early_wlast_bid", int'(bid), 7);
        read_burst(32'h2000, 3, 4'h1, 0, 0);
        write_burst(32'h2000, 3, 4'h6, -1, 0, bresp, bid);
        check_int("missing_wlast_bresp", int'(bresp), 2);
        write_burst(32'h2000, 3, 4'h8, 3, 0, bresp, bid);
        check_int("clean_bresp", int'(bresp), 0);
        check_int("clean_bid", int'(bid), 8);
        write_burst(32'h2040, 0, 4'h2, 0, 0, bresp, bid);
        check_int("len0_bresp", int'(bresp), 0);
        read_burst(32'h2040, 0, 4'h4, 0, 0);
        check_data("len0_value", last_rdata, wdata_tab[0]);

        // byte strobes: low half overwritten with zeros over an all-ones beat
        wdata_tab[0] = '1; wstrb_tab[0] = '1;
        write_burst(32'h3000, 0, 4'h1, 0, 0, bresp, bid);
        wdata_tab[0] = '0; wstrb_tab[0] = 16'h00FF;
        write_burst(32'h3000, 0, 4'h1, 0, 0, bresp, bid);
        read_burst(32'h3000, 0, 4'h1, 0, 0);
        check_data("strobe_half", last_rdata, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

        // index wraps from DEPTH-2 through 0,1; upper and byte-offset address bits ignored
        for (int b = 0; b < 4; b++) begin wdata_tab[b] = {$urandom, $urandom, $urandom, $urandom}; wstrb_tab[b] = '1; end
        write_burst(32'((DEPTH - 2) * BYTES), 3, 4'hC, 3, 0, bresp, bid);
        check_int("wrap_bresp", int'(bresp), 0);
        read_burst(32'((DEPTH - 2) * BYTES), 3, 4'hD, 2, 0);
        read_burst(32'hABCD_0003, 1, 4'hE, 0, 0);
        check_data("wrap_index1", last_rdata, wdata_tab[3]);

        // reset during beat 5 of 16 aborts the read; RAM keeps its contents
        read_burst(32'h100, 15, 4'h2, 0, 5);
        read_burst(32'h100, 15, 4'h2, 2, 0);

        // concurrent write and read on disjoint regions
        for (int b = 0; b < 16; b++) begin wdata_tab[b] = {$urandom, $urandom, $urandom, $urandom}; wstrb_tab[b] = 16'($urandom); end
        fork
            write_burst(32'h100, 15, 4'hB, 15, 1, bresp, bid);
            read_burst(32'h4000, 63, 4'h6, 2, 0);
        join
        check_int("conc_bresp", int'(bresp), 0);
        read_burst(32'h100, 15, 4'h3, 0, 0);

        // random bursts with random strobes inside the filled region
        for (int it = 0; it < 6; it++) begin
            int wl, wi, rl, ri;
            wl = int'($urandom_range(0, 31));
            wi = 1024 + int'($urandom_range(0, 32'(255 - wl)));
            for (int b = 0; b <= wl; b++) begin
                wdata_tab[b] = {$urandom, $urandom, $urandom, $urandom};
                wstrb_tab[b] = 16'($urandom);
            end
            write_burst(32'(wi * BYTES) | 32'($urandom_range(0, 15)), wl, 4'(it), wl, 1, bresp, bid);
            check_int("rand_bresp", int'(bresp), 0);
            check_int("rand_bid", int'(bid), it);
            rl = int'($urandom_range(0, 63));
            ri = 1024 + int'($urandom_range(0, 32'(255 - rl)));
            read_burst(32'(ri * BYTES), rl, 4'(it + 3), 2, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/s_axi_mem_resp.md
Name: s_axi_mem_resp

Overview:
- AXI4 slave memory responder: the far end of the AXI master used by the weight/bias reader and result writer.
- Accepts INCR bursts on independent read and write channels and serves them from an internal block RAM.
- Used as the DDR stand-in for simulation and for on-chip scratch buffering of weights, bias and results.
- Supports one outstanding transaction per direction; reads are full throughput under backpressure.

Parameters:
C_DATA_WIDTH, 128, data bus width in bits; beat size fixed at C_DATA_WIDTH/8 bytes.
C_ADDR_WIDTH, 32, byte address width.
C_MEM_DEPTH, 4096, RAM depth in beats; power of two.

Ports:
I_clk  in  1  clock
I_rst  in  1  asynchronous active-high reset
I_awaddr  in  C_ADDR_WIDTH  write burst byte address
I_awlen  in  8  write beats minus 1
I_awid  in  4  write ID
I_awvalid  in  1  AW valid
O_awready  out  1  AW ready
I_wdata  in  C_DATA_WIDTH  write data
I_wstrb  in  C_DATA_WIDTH/8  byte enables
I_wlast  in  1  last write beat
I_wvalid  in  1  W valid
O_wready  out  1  W ready
O_bresp  out  2  write response
O_bid  out  4  response ID (echo of awid)
O_bvalid  out  1  B valid
I_bready  in  1  B ready
I_araddr  in  C_ADDR_WIDTH  read burst byte address
I_arlen  in  8  read beats minus 1
I_arid  in  4  read ID
I_arvalid  in  1  AR valid
O_arready  out  1  AR ready
O_rdata  out  C_DATA_WIDTH  read data
O_rresp  out  2  read response, always 2'b00
O_rid  out  4  read ID (echo of arid)
O_rlast  out  1  last read beat
O_rvalid  out  1  R valid
I_rready  in  1  R ready

Behaviour:
- Reset: all outputs are 0, both FSMs go to IDLE, and burst counters clear.
- Reset asserted mid-burst aborts the burst and does not return a response. RAM contents are not cleared.
- Address handling: beat index = addr[log2(C_DATA_WIDTH/8) +: log2(C_MEM_DEPTH)]. Low byte-offset bits are ignored.
- The index increments per beat and wraps modulo C_MEM_DEPTH. awburst/arburst/size/cache/prot are not inputs; INCR is implied.
- Write FSM:
  - W_IDLE: O_awready=1. On AW handshake, latch index, awlen and awid, clear the beat counter and the error flag, then go to W_DATA.
  - W_DATA: O_wready=1. Each W handshake writes the RAM with per-byte I_wstrb and increments the index and counter.
  - Error flag sets if I_wlast=1 with counter<awlen, or I_wlast=0 with counter==awlen.
  - The burst ends on the beat where counter==awlen, regardless of wlast; then go to W_RESP.
  - W_RESP: O_bvalid=1, O_bid=latched id, O_bresp=2'b10 (SLVERR) if the error flag is set, else 2'b00.
  - B handshake returns to W_IDLE; O_awready rises on the next cycle.
- Read FSM:
  - R_IDLE: O_arready=1. On AR handshake, latch index, arlen and arid, then go to R_BURST.
  - R_BURST: RAM read latency is 1 cycle, feeding a 2-entry output skid buffer.
  - A RAM read issues whenever the buffer has room, counting entries plus in-flight reads.
  - First O_rvalid appears 2 cycles after the AR handshake.
  - With I_rready held high, one beat transfers per cycle with no bubbles.
  - O_rdata/O_rlast/O_rid stay stable while O_rvalid=1 and I_rready=0.
  - O_rlast=1 only on beat arlen. The R handshake of the last beat returns to R_IDLE.
- Collision: RAM is read-first. A read and a write to the same index in the same cycle return the old data.
- Channels operate concurrently. No ordering is enforced between read and write bursts.
- Length: arlen/awlen 0..255 are all legal. Length 0 gives a single beat with rlast/wlast on beat 0.

Test Plan:
- Write awaddr=0x100, awlen=15, data=beat index, strobe all ones, bready=1; then read the same range -> bresp=00, bid echoed; 16 R beats data 0..15, rlast only on beat 15, first rvalid 2 cycles after AR handshake.
- Read arlen=255 with I_rready toggling 1010... -> 256 beats in order, no beat lost or duplicated, data stable during stalls, O_rvalid continuous 1-per-cycle once rready held high.
- Write awlen=3 with wlast on beat 1 -> four RAM writes occur, bresp=2'b10; a following clean burst -> bresp=2'b00.
- Write strobe 16'h00FF over pre-filled all-ones beat with data 0 -> readback upper 64 bits ones, lower 64 bits zero.
- Write at index C_MEM_DEPTH-2, awlen=3 -> beats land at indices DEPTH-2, DEPTH-1, 0, 1; readback from DEPTH-2 wraps identically.
- Assert I_rst during read beat 5 of 16 -> O_rvalid=0 immediately, O_arready=1 one cycle after release, a new read completes normally.
